// File: rtl/apb_regbank_pkg.sv
// Shared types and helpers for the APB register bank.
package apb_pkg;

  typedef enum logic [1:0] {APB_IDLE, APB_WAIT, APB_ACCESS} apb_state_t;

  localparam int APB_MAX_WAIT = 15;

  function automatic int strb_w(input int dw);
    return dw / 8;
  endfunction

endpackage

// File: rtl/apb_regbank_if.sv
// APB4 bus bundle between the bridge (master) and the register bank (slave).
interface apb_regbank_if #(
  parameter int PADDR_WL = 4,
  parameter int PDATA_WL = 8
);
  import apb_pkg::*;

  logic                          psel;
  logic                          penable;
  logic                          pwrite;
  logic [PADDR_WL-1:0]           paddr;
  logic [PDATA_WL-1:0]           pwdata;
  logic [strb_w(PDATA_WL)-1:0]   pstrb;
  logic                          pready;
  logic [PDATA_WL-1:0]           prdata;
  logic                          pslverr;

  modport master (
    output psel, penable, pwrite, paddr, pwdata, pstrb,
    input  pready, prdata, pslverr
  );

  modport slave (
    input  psel, penable, pwrite, paddr, pwdata, pstrb,
    output pready, prdata, pslverr
  );

endinterface

// File: rtl/apb_regbank_wait_fsm.sv
// APB transfer sequencer: setup capture, programmable wait states, abort on psel drop.
module apb_wait_fsm
  import apb_pkg::*;
#(
  parameter int WAIT_STATES = 0
) (
  input  logic clk,
  input  logic reset_b,
  input  logic psel,
  input  logic penable,
  output logic pready,
  output logic setup_stb,
  output logic commit_stb
);

  localparam logic [3:0] WS4 = 4'(WAIT_STATES);

  apb_state_t state_q, state_d;
  logic [3:0] cnt_q, cnt_d;

  always_ff @(posedge clk or negedge reset_b) begin
    if (!reset_b) begin
      state_q <= APB_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    setup_stb = 1'b0;
    case (state_q)
      APB_IDLE: begin
        // penable already high here is a protocol violation and is ignored
        if (psel && !penable) begin
          setup_stb = 1'b1;
          cnt_d     = WS4;
          state_d   = (WAIT_STATES == 0) ? APB_ACCESS : APB_WAIT;
        end
      end
      APB_WAIT: begin
        if (!psel) begin
          state_d = APB_IDLE;
        end else if (penable) begin
          cnt_d = cnt_q - 4'd1;
          if (cnt_q == 4'd1) state_d = APB_ACCESS;
        end
      end
      APB_ACCESS: state_d = APB_IDLE;
      default:    state_d = APB_IDLE;
    endcase
  end

  assign pready     = (state_q == APB_ACCESS) && psel && penable;
  assign commit_stb = pready;

endmodule

// File: rtl/apb_regbank.sv
// APB4 slave register bank: RW config registers with byte strobes, RO status view,
// per-register write-commit pulses and PSLVERR for bad address / RO writes.
module apb_regbank
  import apb_pkg::*;
#(
  parameter int                  PADDR_WL    = 4,
  parameter int                  NUM_REGS    = 2**PADDR_WL,
  parameter int                  PDATA_WL    = 8,
  parameter int                  WAIT_STATES = 0,
  parameter logic [NUM_REGS-1:0] RO_MASK     = '0
) (
  input  logic                         clk,
  input  logic                         reset_b,
  apb_regbank_if.slave                 bus,
  input  logic [PDATA_WL*NUM_REGS-1:0] status,
  output logic [PDATA_WL*NUM_REGS-1:0] data,
  output logic [NUM_REGS-1:0]          wr_pulse
);

  localparam int SW = strb_w(PDATA_WL);
  localparam int FULL = 2**PADDR_WL;
  localparam logic [FULL-1:0] RO_EXT = FULL'(RO_MASK);

  function automatic logic [PDATA_WL-1:0] merge_bytes(
    input logic [PDATA_WL-1:0] old_v,
    input logic [PDATA_WL-1:0] new_v,
    input logic [SW-1:0]       strb
  );
    merge_bytes = old_v;
    for (int k = 0; k < SW; k++)
      if (strb[k]) merge_bytes[8*k +: 8] = new_v[8*k +: 8];
  endfunction

  logic                pready, setup_stb, commit_stb;
  logic [PADDR_WL-1:0] addr_q;
  logic [PDATA_WL-1:0] wdata_q;
  logic [SW-1:0]       strb_q;
  logic                write_q, err_q;
  logic                in_range, setup_err, commit_wr;
  logic [PDATA_WL-1:0] rd_val, prdata_q;
  logic [PDATA_WL-1:0] regs_q [NUM_REGS];

  apb_wait_fsm #(.WAIT_STATES(WAIT_STATES)) u_fsm (
    .clk        (clk),
    .reset_b    (reset_b),
    .psel       (bus.psel),
    .penable    (bus.penable),
    .pready     (pready),
    .setup_stb  (setup_stb),
    .commit_stb (commit_stb)
  );

  assign in_range  = ({1'b0, bus.paddr} < (PADDR_WL+1)'(NUM_REGS));
  assign setup_err = !in_range || (bus.pwrite && RO_EXT[bus.paddr]);

  always_ff @(posedge clk or negedge reset_b) begin
    if (!reset_b) begin
      write_q <= 1'b0;
      err_q   <= 1'b0;
    end else if (setup_stb) begin
      write_q <= bus.pwrite;
      err_q   <= setup_err;
    end
  end

  always_ff @(posedge clk) begin
    if (setup_stb) begin
      addr_q  <= bus.paddr;
      wdata_q <= bus.pwdata;
      strb_q  <= bus.pstrb;
    end
  end

  // Out-of-range reads fall through to zero; RO registers show live status.
  always_comb begin
    rd_val = '0;
    for (int n = 0; n < NUM_REGS; n++)
      if (bus.paddr == PADDR_WL'(n))
        rd_val = RO_MASK[n] ? status[n*PDATA_WL +: PDATA_WL] : regs_q[n];
  end

  always_ff @(posedge clk or negedge reset_b) begin
    if (!reset_b)                     prdata_q <= '0;
    else if (setup_stb && !bus.pwrite) prdata_q <= rd_val;
  end

  assign commit_wr = commit_stb && write_q && !err_q;

  // RO slots are never written, so they keep their reset value of zero.
  always_ff @(posedge clk or negedge reset_b) begin
    if (!reset_b) begin
      for (int n = 0; n < NUM_REGS; n++) regs_q[n] <= '0;
      wr_pulse <= '0;
    end else begin
      for (int n = 0; n < NUM_REGS; n++) begin
        wr_pulse[n] <= commit_wr && (addr_q == PADDR_WL'(n));
        if (commit_wr && (addr_q == PADDR_WL'(n)) && !RO_MASK[n])
          regs_q[n] <= merge_bytes(regs_q[n], wdata_q, strb_q);
      end
    end
  end

  for (genvar n = 0; n < NUM_REGS; n++) begin : g_data
    assign data[n*PDATA_WL +: PDATA_WL] = regs_q[n];
  end

  assign bus.pready  = pready;
  assign bus.prdata  = prdata_q;
  assign bus.pslverr = pready && err_q;

endmodule

// File: tb/tb_apb_regbank.sv
// Randomised scoreboard bench for apb_regbank (12 x 32-bit regs, 3 wait states, RO regs 2 and 5).
module tb_apb_regbank;

  localparam int NR = 12;
  localparam int DW = 32;
  localparam int WS = 3;
  localparam int DV = NR * DW;
  localparam logic [NR-1:0] RO = 12'h024;

  typedef struct {
    bit              is_rd;
    bit              err;
    logic [DW-1:0]   rd;
    logic [NR-1:0]   pulse;
    logic [DV-1:0]   dvec;
  } exp_t;

  logic          clk = 1'b0;
  logic          reset_b = 1'b0;
  logic [DV-1:0] status_v = '0;
  logic [DV-1:0] data;
  logic [NR-1:0] wr_pulse;

  apb_regbank_if #(.PADDR_WL(4), .PDATA_WL(DW)) bus ();

  apb_regbank #(
    .PADDR_WL(4), .NUM_REGS(NR), .PDATA_WL(DW), .WAIT_STATES(WS), .RO_MASK(RO)
  ) dut (
    .clk      (clk),
    .reset_b  (reset_b),
    .bus      (bus),
    .status   (status_v),
    .data     (data),
    .wr_pulse (wr_pulse)
  );

  always #5 clk = ~clk;

  int        n_cmp = 0;
  int        n_bad = 0;
  exp_t      q[$];
  logic [DW-1:0] mdl [NR];

  task automatic chk(input string nm, input logic [DV-1:0] act, input logic [DV-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic logic [DV-1:0] model_vec();
    logic [DV-1:0] v;
    for (int n = 0; n < NR; n++) v[n*DW +: DW] = RO[n] ? '0 : mdl[n];
    return v;
  endfunction

  // Monitor: prdata/pslverr when pready, then pulse and data on the following cycle.
  bit   pend = 0;
  exp_t pend_e;
  always @(negedge clk) begin
    if (pend) begin
      chk("wr_pulse", DV'(wr_pulse), DV'(pend_e.pulse));
      chk("data", data, pend_e.dvec);
      pend = 0;
    end else if (reset_b) begin
      chk("idle_pulse", DV'(wr_pulse), '0);
    end
    if (bus.pready) begin
      if (q.size() == 0) begin
        n_cmp++; n_bad++;
        $display("FAIL unexpected_pready: got 1 expected 0");
      end else begin
        exp_t e;
        e = q.pop_front();
        chk("pslverr", DV'(bus.pslverr), DV'(e.err));
        if (e.is_rd) chk("prdata", DV'(bus.prdata), DV'(e.rd));
        pend   = 1;
        pend_e = e;
      end
    end
  end

  task automatic xfer(input bit wr, input int addr, input logic [DW-1:0] wd, input logic [3:0] st);
    exp_t e;
    int   n;
    bit   got;
    e.is_rd = !wr;
    e.err   = (addr >= NR) ? 1'b1 : (wr && RO[addr]);
    e.rd    = '0;
    e.pulse = '0;
    if (!wr && !e.err) e.rd = RO[addr] ? status_v[addr*DW +: DW] : mdl[addr];
    if (wr && !e.err) begin
      for (int k = 0; k < 4; k++)
        if (st[k]) mdl[addr][8*k +: 8] = wd[8*k +: 8];
      e.pulse = NR'(1) << addr;
    end
    e.dvec = model_vec();
    q.push_back(e);
    @(posedge clk); #1;
    bus.psel = 1'b1; bus.penable = 1'b0; bus.pwrite = wr;
    bus.paddr = 4'(addr); bus.pwdata = wd; bus.pstrb = st;
    @(posedge clk); #1;
    bus.penable = 1'b1;
    n = 0; got = 0;
    while (n < 20 && !got) begin
      @(negedge clk);
      n++;
      if (bus.pready) got = 1;
    end
    if (!got) begin
      n_cmp++; n_bad++;
      $display("FAIL pready_timeout: got no pready expected pready after %0d cycles", WS + 1);
      if (q.size() > 0) e = q.pop_front();
    end else begin
      chk("latency", DV'(n), DV'(WS + 1));
    end
    @(posedge clk); #1;
    bus.psel = 1'b0; bus.penable = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int n = 0; n < NR; n++) mdl[n] = '0;
    bus.psel = 0; bus.penable = 0; bus.pwrite = 0;
    bus.paddr = '0; bus.pwdata = '0; bus.pstrb = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_data", data, '0);
    chk("rst_pulse", DV'(wr_pulse), '0);
    chk("rst_prdata", DV'(bus.prdata), '0);
    chk("rst_pready", DV'(bus.pready), '0);
    @(negedge clk) reset_b = 1'b1;

    xfer(1, 3, 32'h0000_00A5, 4'b0001);
    xfer(0, 3, '0, 4'h0);
    xfer(1, 0, 32'hFFFF_FFFF, 4'hF);
    xfer(1, 0, 32'h1122_3344, 4'b0101);
    xfer(0, 0, '0, 4'h0);
    xfer(1, 13, 32'hDEAD_BEEF, 4'hF);
    xfer(0, 13, '0, 4'h0);
    status_v[2*DW +: DW] = 32'h0000_003C;
    xfer(0, 2, '0, 4'h0);
    xfer(1, 2, 32'h1234_5678, 4'hF);
    xfer(1, 4, 32'hCAFE_F00D, 4'h0);

    // Abort: psel dropped during wait states.
    @(posedge clk); #1;
    bus.psel = 1; bus.penable = 0; bus.pwrite = 1; bus.paddr = 4'd1;
    bus.pwdata = 32'h5555_AAAA; bus.pstrb = 4'hF;
    @(posedge clk); #1 bus.penable = 1;
    repeat (2) @(posedge clk);
    #1 bus.psel = 0; bus.penable = 0;
    repeat (3) @(posedge clk);
    #1 chk("abort_data", data, model_vec());

    // penable high from IDLE must be ignored.
    @(posedge clk); #1;
    bus.psel = 1; bus.penable = 1; bus.pwrite = 1; bus.paddr = 4'd6;
    bus.pwdata = 32'h0BAD_0BAD; bus.pstrb = 4'hF;
    repeat (3) @(posedge clk);
    #1 bus.psel = 0; bus.penable = 0;
    repeat (2) @(posedge clk);
    #1 chk("violation_data", data, model_vec());

    // Reset while in WAIT.
    @(posedge clk); #1;
    bus.psel = 1; bus.penable = 0; bus.pwrite = 1; bus.paddr = 4'd7;
    bus.pwdata = 32'h7777_7777; bus.pstrb = 4'hF;
    @(posedge clk); #1 bus.penable = 1;
    @(negedge clk);
    reset_b = 1'b0;
    #1;
    for (int n = 0; n < NR; n++) mdl[n] = '0;
    chk("midrst_pready", DV'(bus.pready), '0);
    chk("midrst_data", data, '0);
    chk("midrst_prdata", DV'(bus.prdata), '0);
    bus.psel = 0; bus.penable = 0;
    @(negedge clk) reset_b = 1'b1;
    xfer(1, 7, 32'h0102_0304, 4'hF);
    xfer(0, 7, '0, 4'h0);

    for (int i = 0; i < 150; i++) begin
      if (i % 10 == 0)
        for (int n = 0; n < NR; n++) status_v[n*DW +: DW] = $urandom;
      xfer(1'($urandom_range(0, 1)), int'($urandom_range(0, 15)), $urandom,
           4'($urandom_range(0, 15)));
    end

    repeat (4) @(posedge clk);
    #1 chk("queue_empty", DV'(q.size()), '0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
